hazard_ctrl_sb: RTL and testbench

Next-generation pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational load-use check with a per-register scoreboard and supports a configurable load-result latency. It adds a multi-cycle flush FSM for taken branches, an explicit zero-register exemption on both sources, and saturating stall/flush performance counters. It sits beside the ID stage and drives PC enable, IF/ID enable, ID bubble insertion, IF flush and PC-source select.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_scoreboard.sv | 43 ++++
 rtl/hazard_ctrl_sb.sv | 112 +++++++++++
 tb/tb_hazard_ctrl_sb.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller and the ID-stage decoder.
package hazard_pkg;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register load-latency scoreboard: one down-counter per architectural
// register, armed by an issuing load and looked up for both ID sources.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              ld_we,
  input  logic [REG_AW-1:0] ld_ws,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int unsigned NREG = 2 ** REG_AW;
  localparam int          CW   = $clog2(LOAD_LAT + 1);

  logic [CW-1:0] cnt [NREG];
  logic          set_en;

  // $0 is hardwired, so a load targeting it never arms an entry.
  assign set_en = issue & ld_we & (ld_ws != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (set_en && (ld_ws == REG_AW'(i)))
          cnt[i] <= CW'(LOAD_LAT);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  assign rs_busy = (rs != '0) && (cnt[rs] != '0);
  assign rt_busy = (rt != '0) && (cnt[rt] != '0);

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: scoreboard-based load-use stalls, multi-slot
// branch flush, jump redirect and saturating stall/flush counters.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_ws,
  input  logic              id_is_load,
  input  logic              id_is_jump,
  input  logic              ex_br_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_bubble,
  output logic              if_flush,
  output logic [1:0]        pc_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] FL_INIT = 2'(BR_FLUSH - 1);

  flush_state_t state;
  logic [1:0]   fl_rem;
  logic         rs_busy, rt_busy;
  logic         haz, kill, stall, issue;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .ld_we   (id_is_load & id_we),
    .ld_ws   (id_ws),
    .rs      (id_rs),
    .rt      (id_rt),
    .rs_busy (rs_busy),
    .rt_busy (rt_busy)
  );

  assign haz   = id_valid & ((id_re1 & rs_busy) | (id_re2 & rt_busy));
  assign kill  = (state == FLUSH) | ex_br_taken;
  // A kill discards a pending hazard, so it is neither a stall nor an issue.
  assign stall = haz & ~kill;
  assign issue = id_valid & ~stall & ~kill;

  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_bubble = 1'b0;
    if_flush  = 1'b0;
    pc_sel    = PC_SEQ;
    if (!rst_n) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_bubble = 1'b1;
    end else if (state == FLUSH) begin
      if_flush  = 1'b1;
      id_bubble = 1'b1;
    end else if (ex_br_taken) begin
      pc_sel    = PC_BRANCH;
      if_flush  = 1'b1;
      id_bubble = 1'b1;
    end else if (haz) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_bubble = 1'b1;
    end else if (id_is_jump && id_valid) begin
      pc_sel    = PC_JUMP;
      if_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fl_rem    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_br_taken && (BR_FLUSH > 1)) begin
            state  <= FLUSH;
            fl_rem <= FL_INIT;
          end
        end
        FLUSH: begin
          fl_rem <= fl_rem - 2'd1;
          if (fl_rem == 2'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb (LOAD_LAT=3, BR_FLUSH=2, 8-bit counters):
// the driver queues hand-computed per-cycle expectations, a monitor checks them.
module tb_hazard_ctrl_sb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_re1 = 1'b0, id_re2 = 1'b0, id_we = 1'b0;
  logic       id_is_load = 1'b0, id_is_jump = 1'b0, ex_br_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_ws = '0;
  logic       pc_en, if_id_en, id_bubble, if_flush;
  logic [1:0] pc_sel;
  logic [7:0] stall_cnt, flush_cnt;

  logic       n_rst = 1'b0, n_v = 1'b0, n_re1 = 1'b0, n_re2 = 1'b0, n_we = 1'b0;
  logic       n_ld = 1'b0, n_jmp = 1'b0, n_br = 1'b0;
  logic [4:0] n_rs = '0, n_rt = '0, n_ws = '0;

  typedef struct {
    string      nm;
    logic [5:0] o;
    bit         chk;
    logic [7:0] st;
    logic [7:0] fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  hazard_ctrl_sb #(.REG_AW(5), .LOAD_LAT(3), .BR_FLUSH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_ws(id_ws),
    .id_is_load(id_is_load), .id_is_jump(id_is_jump), .ex_br_taken(ex_br_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_bubble(id_bubble), .if_flush(if_flush),
    .pc_sel(pc_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_bubble, if_flush, pc_sel}
  function automatic logic [5:0] code(input byte k);
    case (k)
      "N":     return 6'b110000;
      "S":     return 6'b001000;
      "B":     return 6'b111110;
      "F":     return 6'b111100;
      "J":     return 6'b110101;
      default: return 6'b001000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic re1, input logic re2, input logic we,
                     input logic [4:0] ws, input logic ld, input logic jmp);
    n_v = v; n_rs = rs; n_rt = rt; n_re1 = re1; n_re2 = re2;
    n_we = we; n_ws = ws; n_ld = ld; n_jmp = jmp;
  endtask

  task automatic step(input string nm, input byte k, input bit chk = 1'b0,
                      input int st = 0, input int fl = 0);
    exp_t e;
    @(posedge clk); #1;
    rst_n = n_rst; id_valid = n_v; id_rs = n_rs; id_rt = n_rt; id_re1 = n_re1;
    id_re2 = n_re2; id_we = n_we; id_ws = n_ws; id_is_load = n_ld;
    id_is_jump = n_jmp; ex_br_taken = n_br;
    n_br = 1'b0;
    e.nm = nm; e.o = code(k); e.chk = chk; e.st = 8'(st); e.fl = 8'(fl);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.nm, ".ctl"}, {26'd0, pc_en, if_id_en, id_bubble, if_flush, pc_sel}, {26'd0, e.o});
      if (e.chk) begin
        check({e.nm, ".stall_cnt"}, {24'd0, stall_cnt}, {24'd0, e.st});
        check({e.nm, ".flush_cnt"}, {24'd0, flush_cnt}, {24'd0, e.fl});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst0", "R", 1, 0, 0);
    step("rst1", "R", 1, 0, 0);
    n_rst = 1'b1;
    step("idle", "N", 1, 0, 0);

    // lw $2,0($1) then add $3,$2,$4: three stall cycles at LOAD_LAT=3
    ins(1, 1, 2, 1, 0, 1, 2, 1, 0);  step("lw2", "N");
    ins(1, 2, 4, 1, 1, 1, 3, 0, 0);
    step("use2_s1", "S"); step("use2_s2", "S"); step("use2_s3", "S");
    step("use2_go", "N", 1, 3, 0);

    // dependent three slots behind the load: one remaining stall
    ins(1, 1, 5, 1, 0, 1, 5, 1, 0);  step("lw5", "N");
    ins(1, 0, 0, 0, 0, 0, 0, 0, 0);  step("ind1", "N"); step("ind2", "N");
    ins(1, 0, 5, 0, 1, 1, 6, 0, 0);  step("use5_s", "S");
    step("use5_go", "N", 1, 4, 0);

    // $0 exemption and ignored rt read when re2=0
    ins(1, 1, 0, 1, 0, 1, 0, 1, 0);  step("lw0", "N");
    ins(1, 0, 0, 1, 1, 1, 8, 0, 0);  step("use0", "N", 1, 4, 0);
    ins(1, 1, 9, 1, 0, 1, 9, 1, 0);  step("lw9", "N");
    ins(1, 0, 9, 1, 0, 1, 8, 0, 0);  step("re2off", "N", 1, 4, 0);

    // taken branch, held high into FLUSH where it is ignored
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_br = 1'b1; step("br", "B");
    n_br = 1'b1; step("br_fl", "F");
    step("br_done", "N", 1, 4, 2);

    // branch + load-use hazard + jump in one cycle: branch wins, no stall
    ins(1, 1, 6, 1, 0, 1, 6, 1, 0);  step("lw6", "N");
    ins(1, 6, 0, 1, 0, 0, 0, 0, 1);
    n_br = 1'b1; step("bhj_br", "B", 1, 4, 2);
    step("bhj_fl", "F");
    step("bhj_haz", "S", 1, 4, 4);
    step("bhj_jmp", "J", 1, 5, 4);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("post_j", "N", 1, 5, 5);

    // lw $7,0($7) repeatedly: 3 stalls per issue, drives stall_cnt to saturation
    ins(1, 7, 0, 1, 0, 1, 7, 1, 0);  step("lw7", "N");
    for (int r = 0; r < 90; r++) begin
      step("sat_s", "S"); step("sat_s", "S"); step("sat_s", "S"); step("sat_go", "N");
    end
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_chk", "N", 1, 255, 5);

    // reset during FLUSH
    n_br = 1'b1; step("br2", "B", 1, 255, 5);
    n_rst = 1'b0; step("rst_fl", "R", 1, 0, 0);
    step("rst_hold", "R", 1, 0, 0);
    n_rst = 1'b1;
    ins(1, 7, 0, 1, 0, 0, 0, 0, 0);
    step("after_rst", "N", 1, 0, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_rst2", "N", 1, 0, 0);

    repeat (2) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
